hps_spi_bridge: RTL
===================

HPS_SPI_BRIDGE -- requirements
Module: hps_spi_bridge

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the SPI word width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter MODE, default 0, giving SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA).
REQ-003 The block SHALL have parameter SYNC, default 2, giving the number of synchroniser stages on spi_clk, spi_cs and spi_mosi (legal range 2..3).
REQ-004 The block SHALL have parameter CNTW, default 8, giving the width of word_cnt.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Ports (name  direction  width  meaning):
- sys_clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from the HPS; asynchronous to sys_clk.
- spi_cs  in  1  chip select; high means deselected.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data; registered.
- tx_data  in  DW  word to send next; sampled at word start.
- tx_ack  out  1  one-cycle pulse when tx_data has been captured.
- rx_data  out  DW  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- word_cnt  out  CNTW  index of the word just received within the current transaction.
- active  out  1  high while the transaction is selected (SHIFT state).

Function
REQ-007 spi_clk, spi_cs and spi_mosi SHALL each pass through SYNC flops before use; there SHALL be no logic clocked by spi_clk.
REQ-008 Edges SHALL be detected on synchronised spi_clk.
- Sample edge = rising when CPOL==CPHA, falling otherwise.
- Shift edge = the opposite edge.
REQ-009 Correct operation SHALL be guaranteed when each spi_clk half-period is at least SYNC+2 sys_clk cycles; there is no requirement below that.
REQ-010 The FSM SHALL have states IDLE and SHIFT.
- IDLE -> SHIFT on synchronised spi_cs falling.
- SHIFT -> IDLE on synchronised spi_cs high.
REQ-011 On IDLE->SHIFT the block SHALL, in the same cycle:
- capture tx_data into the tx shift register;
- pulse tx_ack;
- clear the bit counter;
- set word_cnt to all-ones, so that the first completed word reports 0.
REQ-012 Transmit timing SHALL depend on CPHA:
- CPHA=0: spi_miso presents tx MSB one cycle after the IDLE->SHIFT transition and advances one bit on each shift edge.
- CPHA=1: spi_miso updates on each shift edge, with the first shift edge of a word presenting the MSB.
REQ-013 Each sample edge SHALL shift synchronised spi_mosi into the rx shift register, MSB first, and increment the bit counter modulo DW.
REQ-014 On the DW-th sample edge of a word the block SHALL, in the next cycle:
- load rx_data;
- pulse rx_valid;
- increment word_cnt, wrapping modulo 2^CNTW;
- reload the tx shift register from tx_data and pulse tx_ack.
REQ-015 Back-to-back words within one transaction SHALL continue with no gap; word n+1 begins on the next sample edge.
REQ-016 rx_valid SHALL assert no later than SYNC+2 sys_clk cycles after the DW-th sample edge at the pin.
REQ-017 Deselect mid-word (spi_cs high before DW bits) SHALL:
- discard the partial word, with no rx_valid;
- clear the bit counter;
- hold rx_data and word_cnt.
REQ-018 If synchronised spi_cs rises in the same cycle as the DW-th sample edge is detected, that word SHALL complete (rx_valid pulse) and the FSM SHALL then go to IDLE.
REQ-019 In IDLE, spi_miso SHALL drive 0, and spi_clk and spi_mosi activity SHALL be ignored.
REQ-020 active SHALL be 1 exactly while the FSM is in SHIFT.

Reset
REQ-021 reset_n low SHALL asynchronously force:
- FSM to IDLE;
- spi_miso, tx_ack, rx_valid and active to 0;
- rx_data and word_cnt to 0;
- bit counter, shift registers and synchroniser flops to 0, except the spi_cs synchroniser flops, which go to 1.
REQ-022 Reset asserted mid-transaction SHALL abort the transaction with no rx_valid; after release, the block SHALL wait for a fresh spi_cs falling edge even if spi_cs is already low.
REQ-023 Release of reset_n SHALL take effect on the next sys_clk edge; no operation is required in the first SYNC cycles after release.

Verification
REQ-024 MODE=0, DW=16, tx_data=16'hA55A, one 16-bit transfer with mosi=16'h1234 -> rx_data=16'h1234, one rx_valid, word_cnt=0; master captures 16'hA55A; one tx_ack at start plus one at word end.
REQ-025 MODE=3, DW=32, three back-to-back words 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF -> three rx_valid pulses with word_cnt 0, 1, 2 and the correct data on each.
REQ-026 MODE=1, DW=16, deselect after 9 bits, then a full word 16'h00FF -> no rx_valid for the partial word; next word reports rx_data=16'h00FF, word_cnt=0.
REQ-027 CNTW=2, six words in one transaction -> word_cnt sequence 0, 1, 2, 3, 0, 1.
REQ-028 reset_n pulsed low after 5 bits while spi_cs stays low -> all outputs 0 and no rx_valid until spi_cs goes high then low again, after which a 16-bit word 16'hBEEF is received correctly.
REQ-029 spi_clk half-period set to SYNC+2 sys_clk cycles across all MODE values with random data -> zero bit errors over 1000 words.

Source files
------------

// File: rtl/hps_spi_bridge.sv
// SPI slave bridge: oversamples an HPS-driven SPI bus in the sys_clk domain
// and exchanges DW-bit words with host logic through tx/rx word ports.
module hps_spi_bridge #(
  parameter int unsigned DW   = 16,
  parameter int unsigned MODE = 0,
  parameter int unsigned SYNC = 2,
  parameter int unsigned CNTW = 8
) (
  input  logic            sys_clk,
  input  logic            reset_n,
  input  logic            spi_clk,
  input  logic            spi_cs,
  input  logic            spi_mosi,
  output logic            spi_miso,
  input  logic [DW-1:0]   tx_data,
  output logic            tx_ack,
  output logic [DW-1:0]   rx_data,
  output logic            rx_valid,
  output logic [CNTW-1:0] word_cnt,
  output logic            active
);

  localparam int unsigned BW = $clog2(DW);
  localparam bit CPOL        = ((MODE >> 1) & 1) == 1;
  localparam bit CPHA        = (MODE & 1) == 1;
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SYNC-1:0] r_clk_sync;
  logic [SYNC-1:0] r_cs_sync;
  logic [SYNC-1:0] r_mosi_sync;
  logic [SYNC-1:0] r_init;
  logic            r_clk_prev;
  logic            r_cs_prev;
  logic [BW-1:0]   r_bit_cnt;
  logic [DW-1:0]   r_tx_sr;
  logic [DW-1:0]   r_rx_sr;

  logic w_clk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_init_done;
  logic w_rise;
  logic w_fall;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_cs_fall;
  logic w_start;
  logic w_sample;
  logic w_shift;
  logic w_leave;
  logic w_last;

  // Input synchronisers; r_init marks when the chains hold real pin values
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_init      <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC-2:0], spi_mosi};
      r_init      <= {r_init[SYNC-2:0], 1'b1};
    end
  end

  assign w_clk_s     = r_clk_sync[SYNC-1];
  assign w_cs_s      = r_cs_sync[SYNC-1];
  assign w_mosi_s    = r_mosi_sync[SYNC-1];
  assign w_init_done = r_init[SYNC-1];

  // cs history is held low until the chain is valid, so a select that is
  // already low out of reset is never mistaken for a fresh falling edge
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_clk_prev <= w_clk_s;
      r_cs_prev  <= w_init_done & w_cs_s;
    end
  end

  assign w_rise        = w_clk_s & ~r_clk_prev;
  assign w_fall        = ~w_clk_s & r_clk_prev;
  assign w_sample_edge = SAMPLE_RISE ? w_rise : w_fall;
  assign w_shift_edge  = SAMPLE_RISE ? w_fall : w_rise;
  assign w_cs_fall     = r_cs_prev & ~w_cs_s;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cs_s)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    w_start  = 1'b0;
    w_sample = 1'b0;
    w_shift  = 1'b0;
    w_leave  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: w_start = w_cs_fall;
      S_SHIFT: begin
        w_sample = w_sample_edge;
        w_shift  = w_shift_edge & ~w_cs_s;
        w_leave  = w_cs_s;
        w_last   = w_sample_edge && (r_bit_cnt == BW'(DW - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_miso  <= 1'b0;
      tx_ack    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      word_cnt  <= '0;
      active    <= 1'b0;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
    end else begin
      tx_ack   <= 1'b0;
      rx_valid <= 1'b0;
      active   <= (w_state_nxt == S_SHIFT);

      if (w_start) begin
        r_bit_cnt <= '0;
        word_cnt  <= '1;
        tx_ack    <= 1'b1;
        if (CPHA) begin
          r_tx_sr <= tx_data;
        end else begin
          r_tx_sr  <= {tx_data[DW-2:0], 1'b0};
          spi_miso <= tx_data[DW-1];
        end
      end

      if (w_sample) begin
        r_rx_sr <= {r_rx_sr[DW-2:0], w_mosi_s};
        if (w_last) begin
          r_bit_cnt <= '0;
          rx_data   <= {r_rx_sr[DW-2:0], w_mosi_s};
          rx_valid  <= 1'b1;
          word_cnt  <= word_cnt + CNTW'(1);
          // No reload when the word completes on the deselect itself
          if (!w_cs_s) begin
            r_tx_sr <= tx_data;
            tx_ack  <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end

      if (w_leave && !w_last) r_bit_cnt <= '0;

      if (w_shift) begin
        spi_miso <= r_tx_sr[DW-1];
        r_tx_sr  <= {r_tx_sr[DW-2:0], 1'b0};
      end

      if (w_leave) spi_miso <= 1'b0;
    end
  end

endmodule
